gpo_ctrl_array: RTL and testbench

Parametrised general-purpose-output control register for the PFR CPLD. It replaces fixed bit-position GPO words with a NUM_BITS-wide register written by the Nios over an Avalon-MM slave. Per-bit options are set-only/clear-only writes, self-clearing timed pulses (reset strobes, clear-flag strobes) and a lock that freezes protected bits. The gpo_o bus drives board-level resets, SPI mux selects, filter disables and similar controls.

---
 rtl/gpo_ctrl_array.sv | 143 ++++++++++++++
 tb/tb_gpo_ctrl_array.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpo_ctrl_array.sv
// Purpose: NUM_BITS-wide GPO register behind a small Avalon-MM slave, with
//          set/clear aliases, self-clearing pulse bits and a lock that freezes
//          protected bits.
// Latency: writes show on gpo_o the cycle after the write strobe; readdata
//          is registered one cycle after avmm_read; gpo_changed_o lags the
//          gpo_o change by one cycle.
// Backpressure: none. The slave accepts every access in a single cycle and
//          has no waitrequest.
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   avmm_address             0 DATA, 1 SET, 2 CLR, 3 PULSE_STATUS
//   avmm_write/_writedata    single-cycle write strobe and data
//   avmm_read/_readdata      single-cycle read strobe, registered data
//   lock_i                   1 = LOCK_MASK bits ignore writes
//   gpo_o                    registered outputs
//   pulse_active_o           per-bit pulse timer running
//   gpo_changed_o            one-cycle strobe after any gpo_o change
module gpo_ctrl_array #(
    parameter int unsigned NUM_BITS     = 32,
    parameter logic [31:0] RESET_VALUE  = 32'h0000_0000,
    parameter logic [31:0] PULSE_MASK   = 32'h0000_0000,
    parameter int unsigned PULSE_CYCLES = 16,
    parameter logic [31:0] LOCK_MASK    = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [1:0]          avmm_address,
    input  logic                avmm_write,
    input  logic [31:0]         avmm_writedata,
    input  logic                avmm_read,
    output logic [31:0]         avmm_readdata,
    input  logic                lock_i,
    output logic [NUM_BITS-1:0] gpo_o,
    output logic [NUM_BITS-1:0] pulse_active_o,
    output logic                gpo_changed_o
);

    localparam int unsigned   CW       = $clog2(PULSE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_SET   = 2'd1;
    localparam logic [1:0] ADDR_CLR   = 2'd2;
    localparam logic [1:0] ADDR_PSTAT = 2'd3;

    logic [NUM_BITS-1:0] gpo_q, gpo_d;
    logic [NUM_BITS-1:0] act_q, act_d;
    logic [NUM_BITS-1:0] gpo_dly_q;
    logic                chg_q;
    logic [31:0]         rd_q, rd_d;

    logic [NUM_BITS-1:0] wd, we, wr_hit, wr_val;

    // Writedata bits above NUM_BITS are deliberately dropped.
    logic unused_wd;
    assign unused_wd = ^avmm_writedata;

    assign wd = avmm_writedata[NUM_BITS-1:0];
    // Lock is applied combinationally so a change acts in the cycle it is seen.
    assign we = ~({NUM_BITS{lock_i}} & LOCK_MASK[NUM_BITS-1:0]);

    // wr_hit: this bit is written this cycle; wr_val: the value it receives.
    always_comb begin
        wr_hit = '0;
        wr_val = '0;
        if (avmm_write) begin
            case (avmm_address)
                ADDR_DATA: begin wr_hit = we;      wr_val = wd; end
                ADDR_SET:  begin wr_hit = we & wd; wr_val = '1; end
                ADDR_CLR:  begin wr_hit = we & wd; wr_val = '0; end
                default:   ;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_BITS; i++) begin : g_bit
        if (PULSE_MASK[i]) begin : g_pulse
            logic [CW-1:0] cnt_q, cnt_d;
            logic          bit_d, act_bit_d;

            // A write always beats the timer; writing 1 (re)loads it, writing
            // 0 kills the pulse at once. The counter runs PULSE_CYCLES-1..0 and
            // the bit drops on the cycle after it reaches 0.
            always_comb begin
                bit_d     = gpo_q[i];
                act_bit_d = act_q[i];
                cnt_d     = cnt_q;
                if (wr_hit[i]) begin
                    bit_d     = wr_val[i];
                    act_bit_d = wr_val[i];
                    cnt_d     = wr_val[i] ? CNT_LOAD : '0;
                end else if (act_q[i]) begin
                    if (cnt_q == '0) begin
                        bit_d     = 1'b0;
                        act_bit_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) cnt_q <= '0;
                else         cnt_q <= cnt_d;
            end

            assign gpo_d[i] = bit_d;
            assign act_d[i] = act_bit_d;
        end else begin : g_plain
            assign gpo_d[i] = wr_hit[i] ? wr_val[i] : gpo_q[i];
            assign act_d[i] = 1'b0;
        end
    end

    // Read mux samples pre-write state, so a same-cycle write is not visible.
    always_comb begin
        rd_d = '0;
        if (avmm_address == ADDR_PSTAT) rd_d[NUM_BITS-1:0] = act_q;
        else                            rd_d[NUM_BITS-1:0] = gpo_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gpo_q     <= RESET_VALUE[NUM_BITS-1:0];
            act_q     <= '0;
            gpo_dly_q <= RESET_VALUE[NUM_BITS-1:0];
            chg_q     <= 1'b0;
            rd_q      <= '0;
        end else begin
            gpo_q     <= gpo_d;
            act_q     <= act_d;
            gpo_dly_q <= gpo_q;
            chg_q     <= (gpo_q != gpo_dly_q);
            if (avmm_read) rd_q <= rd_d;
        end
    end

    assign gpo_o          = gpo_q;
    assign pulse_active_o = act_q;
    assign gpo_changed_o  = chg_q;
    assign avmm_readdata  = rd_q;

endmodule

// File: tb/tb_gpo_ctrl_array.sv
module tb_gpo_ctrl_array;

    localparam logic [31:0] RV  = 32'h0000_0403;
    localparam logic [31:0] PM  = 32'h0002_0000;
    localparam int          PC  = 4;
    localparam logic [31:0] LM  = 32'h0000_0003;
    localparam logic [31:0] B17 = 32'h0002_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [1:0]  avmm_address = '0;
    logic        avmm_write = 1'b0;
    logic [31:0] avmm_writedata = '0;
    logic        avmm_read = 1'b0;
    logic [31:0] avmm_readdata;
    logic        lock_i = 1'b0;
    logic [31:0] gpo_o;
    logic [31:0] pulse_active_o;
    logic        gpo_changed_o;

    always #5 clk = ~clk;

    gpo_ctrl_array #(
        .NUM_BITS(32), .RESET_VALUE(RV), .PULSE_MASK(PM),
        .PULSE_CYCLES(PC), .LOCK_MASK(LM)
    ) dut (
        .clk(clk), .resetn(resetn),
        .avmm_address(avmm_address), .avmm_write(avmm_write),
        .avmm_writedata(avmm_writedata), .avmm_read(avmm_read),
        .avmm_readdata(avmm_readdata), .lock_i(lock_i),
        .gpo_o(gpo_o), .pulse_active_o(pulse_active_o),
        .gpo_changed_o(gpo_changed_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference model: each pulse bit holds the absolute edge number at which
    // it must fall (-1 = no pulse pending); everything else is plain values.
    logic [31:0] m_gpo, m_prev, m_rd;
    logic        m_chg;
    int          m_fall[32];
    int          edge_no = 0;

    function automatic logic [31:0] m_act();
        logic [31:0] a = '0;
        for (int i = 0; i < 32; i++) a[i] = (m_fall[i] != -1);
        return a;
    endfunction

    task automatic model_reset();
        m_gpo  = RV;
        m_prev = RV;
        m_rd   = '0;
        m_chg  = 1'b0;
        for (int i = 0; i < 32; i++) m_fall[i] = -1;
    endtask

    task automatic model_edge(input logic w, input logic [1:0] a, input logic [31:0] d,
                              input logic r, input logic lk);
        logic [31:0] pre_gpo, pre_act, pmask, lmask;
        logic        hit, val;
        pmask   = PM;
        lmask   = LM;
        edge_no++;
        pre_gpo = m_gpo;
        pre_act = m_act();
        m_chg   = (pre_gpo != m_prev);
        m_prev  = pre_gpo;
        if (r) m_rd = (a == 2'd3) ? pre_act : pre_gpo;
        for (int i = 0; i < 32; i++) begin
            hit = 1'b0;
            val = 1'b0;
            if (w && !(lk && lmask[i])) begin
                if (a == 2'd0)      begin hit = 1'b1; val = d[i]; end
                else if (a == 2'd1) begin hit = d[i]; val = 1'b1; end
                else if (a == 2'd2) begin hit = d[i]; val = 1'b0; end
            end
            if (hit) begin
                m_gpo[i] = val;
                if (pmask[i]) m_fall[i] = val ? edge_no + PC : -1;
            end else if (m_fall[i] == edge_no) begin
                m_gpo[i]  = 1'b0;
                m_fall[i] = -1;
            end
        end
    endtask

    task automatic compare_all(input string pfx);
        check({pfx, "_gpo"},  gpo_o, m_gpo);
        check({pfx, "_pact"}, pulse_active_o, m_act());
        check({pfx, "_chg"},  {31'b0, gpo_changed_o}, {31'b0, m_chg});
        check({pfx, "_rd"},   avmm_readdata, m_rd);
    endtask

    task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d,
                        input logic r, input logic lk);
        @(negedge clk);
        avmm_write     = w;
        avmm_address   = a;
        avmm_writedata = d;
        avmm_read      = r;
        lock_i         = lk;
        @(posedge clk);
        model_edge(w, a, d, r, lk);
        #1;
        compare_all("cyc");
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic lk);
        step(1'b1, a, d, 1'b0, lk);
    endtask

    task automatic rd(input logic [1:0] a);
        step(1'b0, a, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted between clock edges, checked before any edge.
    task automatic async_reset();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        compare_all("arst");
        @(negedge clk);
        resetn = 1'b1;
    endtask

    int hc;

    initial begin
        model_reset();
        #1;
        resetn = 1'b0;
        #1;
        compare_all("rst");
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Read after reset
        rd(2'd0);
        check("rst_read", avmm_readdata, 32'h0000_0403);
        check("rst_nochg", {31'b0, gpo_changed_o}, 32'h0);

        // SET / CLR / DATA
        wr(2'd1, 32'h10, 1'b0);
        check("set", gpo_o, 32'h413);
        idle();
        check("set_strobe", {31'b0, gpo_changed_o}, 32'h1);
        idle();
        check("set_strobe_end", {31'b0, gpo_changed_o}, 32'h0);
        wr(2'd2, 32'h01, 1'b0);
        check("clr", gpo_o, 32'h412);
        idle();
        wr(2'd0, 32'hF0, 1'b0);
        check("data", gpo_o, 32'hF0);
        idle();
        idle();

        // Single pulse with a mid-pulse status read
        hc = 0;
        wr(2'd1, B17, 1'b0);
        if (gpo_o[17]) hc++;
        rd(2'd3);
        if (gpo_o[17]) hc++;
        check("pstat_mid", avmm_readdata, B17);
        for (int k = 0; k < 8; k++) begin
            idle();
            if (gpo_o[17]) hc++;
        end
        check("pulse_len", hc, 4);
        rd(2'd3);
        check("pstat_end", avmm_readdata, 32'h0);

        // Retrigger two cycles in
        hc = 0;
        wr(2'd1, B17, 1'b0);
        if (gpo_o[17]) hc++;
        idle();
        if (gpo_o[17]) hc++;
        wr(2'd1, B17, 1'b0);
        if (gpo_o[17]) hc++;
        for (int k = 0; k < 10; k++) begin
            idle();
            if (gpo_o[17]) hc++;
        end
        check("retrig_len", hc, 6);

        // Clear two cycles in
        wr(2'd1, B17, 1'b0);
        idle();
        wr(2'd2, B17, 1'b0);
        check("clr_pulse_gpo", gpo_o & B17, 32'h0);
        check("clr_pulse_act", pulse_active_o, 32'h0);
        idle();
        idle();

        // Lock
        wr(2'd0, 32'h0, 1'b0);
        wr(2'd0, 32'hFF, 1'b1);
        check("lock_on", gpo_o, 32'hFC);
        wr(2'd0, 32'hFF, 1'b0);
        check("lock_off", gpo_o, 32'hFF);

        // Reset mid-pulse (counter at 2), no resume afterwards
        wr(2'd1, B17, 1'b0);
        idle();
        async_reset();
        check("arst_gpo", gpo_o, 32'h403);
        check("arst_act", pulse_active_o, 32'h0);
        for (int k = 0; k < 8; k++) idle();
        check("no_resume", gpo_o, 32'h403);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            logic [31:0] d;
            logic [1:0]  a;
            a = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       d = $urandom;
                1:       d = B17;
                2:       d = 32'($urandom_range(0, 3)) | (($urandom_range(0, 1) == 1) ? B17 : 32'h0);
                default: d = $urandom & 32'h0002_00FF;
            endcase
            step(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, a, d,
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
